// File: rtl/float_to_int_arbiter.sv
// Round-robin arbiter sharing one combinational float-to-int converter among NUM_REQ requesters.
// Optional macro F2I_ARB_SATURATE_EN saturates the captured integer using the overflow/underflow flags.
module float_to_int_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [13*NUM_REQ-1:0]  req_float_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [12:0]            conv_float_o,
  input  logic [7:0]             conv_int_i,
  input  logic                   conv_overflow_i,
  input  logic                   conv_underflow_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [7:0]             resp_int_o,
  output logic                   resp_overflow_o,
  output logic                   resp_underflow_o
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ID_W-1:0]       r_last_grant;
  logic [ID_W-1:0]       r_id_p0;
  logic [12:0]           r_conv_float_p0;
  logic                  r_resp_valid_p1;
  logic [ID_W-1:0]       r_resp_id_p1;
  logic signed [7:0]     r_resp_int_p1;
  logic                  r_resp_ovf_p1;
  logic                  r_resp_unf_p1;

  logic                  w_any;
  logic [ID_W-1:0]       w_pick;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_complete;
  logic signed [7:0]     w_int_p0;

`ifdef F2I_ARB_SATURATE_EN
  function automatic logic signed [7:0] f_saturate(input logic signed [7:0] raw,
                                                   input logic ovf, input logic unf,
                                                   input logic sign);
    if (ovf)      return sign ? 8'sh80 : 8'sh7F;
    else if (unf) return 8'sh00;
    else          return raw;
  endfunction
`endif

  // Round-robin search: the lowest offset from last_grant+1 wins, so scan offsets downward.
  always_comb begin
    int v_idx;
    w_any  = 1'b0;
    w_pick = '0;
    v_idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (req_valid_i[v_idx]) begin
        w_any  = 1'b1;
        w_pick = ID_W'(v_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any)        w_next_state = CONVERT;
      CONVERT:                   w_next_state = RESPOND;
      RESPOND: if (resp_ready_i) w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready[w_pick] = 1'b1;
          w_accept            = 1'b1;
        end
      end
      CONVERT: w_capture  = 1'b1;
      RESPOND: w_complete = resp_ready_i;
      default: ;
    endcase
  end

`ifdef F2I_ARB_SATURATE_EN
  assign w_int_p0 = f_saturate(conv_int_i, conv_overflow_i, conv_underflow_i, r_conv_float_p0[12]);
`else
  assign w_int_p0 = conv_int_i;
`endif

  // p0: operand latched on accept and held for the converter through CONVERT and beyond
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conv_float_p0 <= '0;
      r_id_p0         <= '0;
    end else if (w_accept) begin
      r_conv_float_p0 <= req_float_i[13*w_pick +: 13];
      r_id_p0         <= w_pick;
    end
  end

  // p1: converter result captured once and held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid_p1 <= 1'b0;
      r_resp_id_p1    <= '0;
      r_resp_int_p1   <= '0;
      r_resp_ovf_p1   <= 1'b0;
      r_resp_unf_p1   <= 1'b0;
      r_last_grant    <= ID_W'(NUM_REQ - 1);
    end else if (w_capture) begin
      r_resp_valid_p1 <= 1'b1;
      r_resp_id_p1    <= r_id_p0;
      r_resp_int_p1   <= w_int_p0;
      r_resp_ovf_p1   <= conv_overflow_i;
      r_resp_unf_p1   <= conv_underflow_i;
    end else if (w_complete) begin
      r_resp_valid_p1 <= 1'b0;
      r_last_grant    <= r_resp_id_p1;
    end
  end

  assign req_ready_o      = w_req_ready;
  assign conv_float_o     = r_conv_float_p0;
  assign resp_valid_o     = r_resp_valid_p1;
  assign resp_id_o        = r_resp_id_p1;
  assign resp_int_o       = r_resp_int_p1;
  assign resp_overflow_o  = r_resp_ovf_p1;
  assign resp_underflow_o = r_resp_unf_p1;

endmodule

// File: tb/tb_float_to_int_arbiter.sv
// Scoreboard bench for float_to_int_arbiter with a behavioural converter stub.
module tb_float_to_int_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [13*NUM_REQ-1:0] req_float_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [12:0]           conv_float_o;
  logic [7:0]            conv_int_i;
  logic                  conv_overflow_i;
  logic                  conv_underflow_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [ID_W-1:0]       resp_id_o;
  logic [7:0]            resp_int_o;
  logic                  resp_overflow_o;
  logic                  resp_underflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] sb_q[$];

  float_to_int_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_float_i(req_float_i), .req_ready_o(req_ready_o),
    .conv_float_o(conv_float_o), .conv_int_i(conv_int_i),
    .conv_overflow_i(conv_overflow_i), .conv_underflow_i(conv_underflow_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_int_o(resp_int_o), .resp_overflow_o(resp_overflow_o),
    .resp_underflow_o(resp_underflow_o)
  );

  assign conv_int_i       = conv_float_o[7:0];
  assign conv_overflow_i  = conv_float_o[8];
  assign conv_underflow_i = conv_float_o[9];

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Expected response word: {id[1:0], int[7:0], ovf, unf}
  function automatic logic [11:0] pack(input int id, input logic [7:0] iv, input logic o, input logic u);
    return {id[1:0], iv, o, u};
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid_o && resp_ready_i) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_id_o), 32'hFFFF);
      end else begin
        check("resp", 32'({resp_id_o, resp_int_o, resp_overflow_o, resp_underflow_o}),
              32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [12:0] f);
    req_valid_i[id]         = 1'b1;
    req_float_i[13*id +: 13] = f;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((resp_valid_o || sb_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic one_req(input string name, input int id, input logic [12:0] f,
                         input logic [7:0] ei, input logic eo, input logic eu);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    set_req(id, f);
    sb_q.push_back(pack(id, ei, eo, eu));
    #1;
    check({name, "_ready"}, 32'(req_ready_o), 32'(oh));
    step();
    req_valid_i = '0;
    drain({name, "_drain"});
  endtask

  initial begin
    int accepts;
    int last_cyc;
    int cyc;
    logic [NUM_REQ-1:0] oh;
    rst_n        = 1'b0;
    req_valid_i  = '0;
    req_float_i  = '0;
    resp_ready_i = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(resp_valid_o), 0);
    check("rst_conv_float", 32'(conv_float_o), 0);
    check("rst_resp", 32'({resp_id_o, resp_int_o, resp_overflow_o, resp_underflow_o}), 0);
    check("rst_ready", 32'(req_ready_o), 0);
    rst_n = 1'b1;
    step();

    // Single request with latency check
    set_req(2, 13'h005A);
    sb_q.push_back(pack(2, 8'h5A, 1'b0, 1'b0));
    #1;
    check("single_ready", 32'(req_ready_o), 32'b0100);
    step();
    req_valid_i = '0;
    check("single_conv_float", 32'(conv_float_o), 32'h005A);
    check("single_lat1_valid", 32'(resp_valid_o), 0);
    check("single_busy_ready", 32'(req_ready_o), 0);
    step();
    check("single_lat2_valid", 32'(resp_valid_o), 1);
    step();
    check("single_done_valid", 32'(resp_valid_o), 0);
    drain("single_drain");

    // Round robin from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 13'(16 + i));
    for (int i = 0; i < 5; i++) sb_q.push_back(pack(i % 4, 8'(16 + (i % 4)), 1'b0, 1'b0));
    accepts = 0; last_cyc = 0; cyc = 0;
    while (accepts < 5 && cyc < 40) begin
      #1;
      if (req_ready_o != '0) begin
        oh = '0;
        oh[accepts % 4] = 1'b1;
        check("rr_grant", 32'(req_ready_o), 32'(oh));
        if (accepts > 0) check("rr_spacing", 32'(cyc - last_cyc), 3);
        last_cyc = cyc;
        accepts++;
      end
      step();
      cyc++;
    end
    check("rr_accepts", 32'(accepts), 5);
    req_valid_i = '0;
    drain("rr_drain");

    // Backpressure: pointer now at 0, so requester 1 wins
    resp_ready_i = 1'b0;
    set_req(1, 13'h0033);
    sb_q.push_back(pack(1, 8'h33, 1'b0, 1'b0));
    #1;
    check("bp_ready", 32'(req_ready_o), 32'b0010);
    step();
    req_valid_i = '0;
    set_req(2, 13'h0044);
    sb_q.push_back(pack(2, 8'h44, 1'b0, 1'b0));
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", 32'(resp_valid_o), 1);
      check("bp_hold_data", 32'({resp_id_o, resp_int_o}), 32'({2'd1, 8'h33}));
      check("bp_hold_ready", 32'(req_ready_o), 0);
      step();
    end
    resp_ready_i = 1'b1;
    step();
    #1;
    check("bp_complete_valid", 32'(resp_valid_o), 0);
    check("bp_next_ready", 32'(req_ready_o), 32'b0100);
    step();
    req_valid_i = '0;
    drain("bp_drain");

    // Reset mid-flight drops the transaction and restores requester 0 priority
    set_req(0, 13'h0077);
    step();
    req_valid_i = '0;
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(resp_valid_o), 0);
    check("midrst_conv_float", 32'(conv_float_o), 0);
    rst_n = 1'b1;
    set_req(1, 13'h0021);
    set_req(3, 13'h0023);
    sb_q.push_back(pack(1, 8'h21, 1'b0, 1'b0));
    #1;
    check("midrst_grant", 32'(req_ready_o), 32'b0010);
    step();
    req_valid_i = '0;
    drain("midrst_drain");

    // Flags, with and without saturation
`ifdef F2I_ARB_SATURATE_EN
    one_req("ovf_neg", 2, 13'h1180, 8'h80, 1'b1, 1'b0);
    one_req("unf",     3, 13'h0255, 8'h00, 1'b0, 1'b1);
    one_req("ovf_pos", 0, 13'h0112, 8'h7F, 1'b1, 1'b0);
`else
    one_req("ovf_neg", 2, 13'h1180, 8'h80, 1'b1, 1'b0);
    one_req("unf",     3, 13'h0255, 8'h55, 1'b0, 1'b1);
    one_req("ovf_pos", 0, 13'h0112, 8'h12, 1'b1, 1'b0);
`endif
    check("final_sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/float_to_int_arbiter.md
Name: float_to_int_arbiter

Overview:
Shares one combinational float_to_int_converter (13-bit float in; 8-bit signed int, overflow and underflow out) between NUM_REQ independent requesters. Each requester uses a valid/ready handshake. A round-robin scheduler grants one requester at a time and drives the converter from a registered operand. It captures the converter result and returns it, tagged with the requester ID, on a single response channel with backpressure. Sits between the request sources and the converter instance in the conversion subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester request valid
req_float_i  input  13*NUM_REQ  per-requester float operand; requester k uses bits [13k+12:13k]
req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero
conv_float_o  output  13  operand to the shared converter
conv_int_i  input  8  converter integer result
conv_overflow_i  input  1  converter overflow flag
conv_underflow_i  input  1  converter underflow flag
resp_valid_o  output  1  response valid
resp_ready_i  input  1  response consumer ready
resp_id_o  output  ID_W  requester index of the response
resp_int_o  output  8  converted integer
resp_overflow_o  output  1  captured overflow
resp_underflow_o  output  1  captured underflow

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; conv_float_o=0; resp_valid_o=0; resp_id_o=0; resp_int_o=0; both flags 0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - Reset has priority over every other event, in any state. A transaction in flight is dropped without a response.
- FSM states: IDLE, CONVERT, RESPOND.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit searching upward from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready_o is asserted combinationally in the same cycle, for that bit only.
  - On the edge: latch the operand into conv_float_o, latch the ID, go to CONVERT.
  - If no request is valid, req_ready_o=0 and the FSM stays in IDLE.
- CONVERT:
  - conv_float_o is held stable for the whole cycle, so the converter settles.
  - On the edge: capture conv_int_i and both flags into the resp_* registers, set resp_valid_o=1, go to RESPOND.
- RESPOND:
  - resp_valid_o=1 and all resp_* outputs are held stable until resp_ready_i=1.
  - On the handshake edge: resp_valid_o=0, last_grant=latched ID, go to IDLE.
- req_ready_o=0 in CONVERT and RESPOND. No new request is accepted until the response completes.
- Latency and throughput:
  - Accept at edge N gives resp_valid_o high after edge N+1, a 2-cycle latency.
  - Maximum throughput is one conversion per 3 cycles.
- Fairness: the pointer updates only on response completion. A requester that is continuously valid is served at least once every NUM_REQ transactions.
- Requesters must hold req_valid_i and req_float_i until they see req_ready_o. A request withdrawn without ready is simply not served.
- conv_float_o keeps its last value in IDLE. It changes only on accept.

Optional Feature:
- Macro: F2I_ARB_SATURATE_EN.
- When defined, the integer is saturated at capture in CONVERT, using the latched operand's sign bit conv_float_o[12]:
  - overflow with sign=0 gives resp_int_o=8'h7F;
  - overflow with sign=1 gives 8'h80;
  - underflow gives 8'h00;
  - otherwise conv_int_i is passed through.
  - The flags are still reported unchanged.
- When not defined, conv_int_i is captured unmodified.

Test Plan:
All scenarios use a behavioural converter stub: conv_int_i=conv_float_o[7:0], conv_overflow_i=conv_float_o[8], conv_underflow_i=conv_float_o[9].
- Single request: requester 2 valid with 13'h005A, resp_ready_i=1 -> req_ready_o=4'b0100 in the accept cycle; 2 cycles later resp_valid_o=1, resp_id_o=2, resp_int_o=8'h5A, both flags 0.
- Round-robin: all 4 requesters valid continuously with operands 13'h0010..13'h0013 -> response IDs in order 0,1,2,3,0, each int matching its operand; every request is accepted 3 cycles after the previous one.
- Backpressure: resp_ready_i=0 for 5 cycles during RESPOND -> resp_* outputs are held stable; req_ready_o stays 0; completion occurs on the first cycle resp_ready_i=1.
- Reset mid-flight: rst_n=0 during CONVERT -> next cycle resp_valid_o=0 and state is IDLE; with requesters 1 and 3 valid, requester 1 is granted first.
- Flags: operand 13'h1180 (sign=1, stub overflow=1) -> resp_overflow_o=1. resp_int_o=8'h80 with F2I_ARB_SATURATE_EN defined, otherwise 8'h80 raw. Operand 13'h0255 -> resp_underflow_o=1, resp_int_o=8'h00 when saturating, 8'h55 without.
